// File: rtl/prog_dumper_pkg.sv
// Shared constants and types for the program dump/load path.
package prog_dumper_pkg;

    localparam int ADR_WIDTH       = 21;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_STOP_BITS  = 1;
    localparam int UART_FRAME_BITS = 1 + UART_DATA_BITS + UART_STOP_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_NEXT  = 2'd3
    } dump_state_t;

    // Saturating address step: never moves past the final address.
    function automatic logic [ADR_WIDTH-1:0] adr_inc(
        input logic [ADR_WIDTH-1:0] a,
        input logic [ADR_WIDTH-1:0] last
    );
        return (a == last) ? a : a + ADR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/prog_dumper_if.sv
// Memory read bus between the dumper and the external program memory.
interface prog_dumper_if;
    import prog_dumper_pkg::*;

    logic [ADR_WIDTH-1:0]      adr;
    logic                      read;
    logic [UART_DATA_BITS-1:0] data;

    modport master (output adr, output read, input data);
    modport slave  (input adr, input read, output data);
endinterface

// File: rtl/prog_dumper_uart_tx.sv
// 8N1 UART serializer. idle is high whenever a new go is accepted,
// including the final stop-bit cycle, so frames can run back to back.
module uart_tx
    import prog_dumper_pkg::*;
#(
    parameter int CLK_DIV = 104
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] tx_byte,
    input  logic                      go,
    output logic                      tx,
    output logic                      idle
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLK_DIV - 2);
    localparam logic [3:0]    BIT_STOP  = 4'(UART_FRAME_BITS - 1);
    localparam logic [3:0]    BIT_LASTD = 4'(UART_DATA_BITS);

    logic                      r_active;
    logic                      r_idle;
    logic                      r_tx;
    logic [BW-1:0]             r_baud;
    logic [3:0]                r_bit;
    logic [UART_DATA_BITS-1:0] r_shift;

    // Baud/bit sequencing and shift register for one frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_idle   <= 1'b1;
            r_tx     <= 1'b1;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_shift  <= '0;
        end else if (go && r_idle) begin
            r_active <= 1'b1;
            r_idle   <= 1'b0;
            r_tx     <= 1'b0;
            r_baud   <= '0;
            r_bit    <= 4'd0;
            r_shift  <= tx_byte;
        end else if (r_active) begin
            if (r_baud == BAUD_LAST) begin
                r_baud <= '0;
                if (r_bit == BIT_STOP) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                    r_bit    <= 4'd0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    if (r_bit == BIT_LASTD) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
            end else begin
                r_baud <= r_baud + BW'(1);
            end
            if ((r_bit == BIT_STOP) && (r_baud == BAUD_PRE)) begin
                r_idle <= 1'b1;
            end
        end
    end

    assign tx   = r_tx;
    assign idle = r_idle;

endmodule

// File: rtl/prog_dumper.sv
// Reads memory from address 0 to LAST_ADR and streams each byte out as 8N1.
module prog_dumper
    import prog_dumper_pkg::*;
#(
    parameter int                   CLK_DIV   = 104,
    parameter int                   READ_WAIT = 3,
    parameter logic [ADR_WIDTH-1:0] LAST_ADR  = 21'h1FFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    prog_dumper_if.master mem,
    output logic          tx,
    output logic          busy,
    output logic          done
);

    localparam int WW = $clog2(READ_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_WAIT - 1);

    dump_state_t          r_state;
    dump_state_t          w_next;
    logic [ADR_WIDTH-1:0] r_adr;
    logic [WW-1:0]        r_wait;
    logic                 r_read;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_go;
    logic                 w_last_adr;
    logic                 w_uart_idle;
    logic                 w_uart_tx;

    assign w_last_adr = (r_adr == LAST_ADR);

    // Next-state decode; go fires on the last FETCH cycle so the start bit
    // appears on the first SEND cycle.
    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_FETCH;
                else       w_next = ST_IDLE;
            end
            ST_FETCH: begin
                if (r_wait == WAIT_LAST) begin
                    w_next = ST_SEND;
                    w_go   = 1'b1;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_SEND: begin
                if (w_uart_idle) w_next = ST_NEXT;
                else             w_next = ST_SEND;
            end
            ST_NEXT: begin
                if (w_last_adr) w_next = ST_IDLE;
                else            w_next = ST_FETCH;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Address counter, read-wait counter and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adr  <= '0;
            r_wait <= '0;
            r_read <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_read <= (w_next == ST_FETCH);
            r_done <= (r_state == ST_SEND) && (w_next == ST_NEXT) && w_last_adr;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_adr  <= '0;
                        r_busy <= 1'b1;
                        r_wait <= '0;
                    end
                end
                ST_FETCH: begin
                    if (w_next == ST_FETCH) r_wait <= r_wait + WW'(1);
                    else                    r_wait <= '0;
                end
                ST_NEXT: begin
                    r_wait <= '0;
                    if (w_last_adr) r_busy <= 1'b0;
                    else            r_adr  <= adr_inc(r_adr, LAST_ADR);
                end
                default: ;
            endcase
        end
    end

    uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
        .clk     (clk),
        .reset   (reset),
        .tx_byte (mem.data),
        .go      (w_go),
        .tx      (w_uart_tx),
        .idle    (w_uart_idle)
    );

    assign mem.adr  = r_adr;
    assign mem.read = r_read;
    assign tx       = w_uart_tx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_prog_dumper.sv
// Directed/randomised bench for prog_dumper: per-cycle logs are compared
// against frames built from the 8N1 rules and the address/timing schedule.
module tb_prog_dumper;
    import prog_dumper_pkg::*;

    localparam int D    = 4;
    localparam int RW   = 2;
    localparam int NB   = 16;
    localparam int PER  = RW + 10 * D + 1;
    localparam int LOGN = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    logic tx1, busy1, done1, tx2, busy2, done2;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic rp1 = 1'b0;
    logic rp2 = 1'b0;

    prog_dumper_if mif1();
    prog_dumper_if mif2();
    assign mif1.data = data1;
    assign mif2.data = data2;

    prog_dumper #(.CLK_DIV(D), .READ_WAIT(RW), .LAST_ADR(21'd15)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .mem(mif1),
        .tx(tx1), .busy(busy1), .done(done1));

    prog_dumper #(.CLK_DIV(D), .READ_WAIT(RW), .LAST_ADR(21'd0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mem(mif2),
        .tx(tx2), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        tx1_log   [LOGN];
    logic        read1_log [LOGN];
    logic        busy1_log [LOGN];
    logic        done1_log [LOGN];
    logic [20:0] adr1_log  [LOGN];
    logic        tx2_log   [LOGN];
    logic        read2_log [LOGN];
    logic        done2_log [LOGN];
    logic [7:0]  mem1      [NB];

    // Log outputs each cycle; memory drives valid data only on the last read
    // cycle and random junk otherwise.
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            tx1_log[cyc]   <= tx1;
            read1_log[cyc] <= mif1.read;
            busy1_log[cyc] <= busy1;
            done1_log[cyc] <= done1;
            adr1_log[cyc]  <= mif1.adr;
            tx2_log[cyc]   <= tx2;
            read2_log[cyc] <= mif2.read;
            done2_log[cyc] <= done2;
        end
        rp1   <= mif1.read;
        rp2   <= mif2.read;
        data1 <= (mif1.read && rp1) ? mem1[mif1.adr[3:0]] : 8'($urandom);
        data2 <= (mif2.read && rp2) ? 8'h00 : 8'($urandom);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Count cycles where the logged tx differs from the ideal 8N1 frame.
    function automatic int frame_errs(input int sel, input int s, input logic [7:0] b);
        int e = 0;
        logic expb;
        logic got;
        for (int j = 0; j < 10 * D; j++) begin
            int k = j / D;
            if (k == 0)      expb = 1'b0;
            else if (k == 9) expb = 1'b1;
            else             expb = b[k-1];
            got = (sel == 1) ? tx1_log[s+j] : tx2_log[s+j];
            if (got !== expb) e++;
        end
        return e;
    endfunction

    task automatic quiet_check(input string tag);
        int q = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0 || mif1.read !== 1'b0 || done1 !== 1'b0) q++;
        end
        check(tag, q, 0);
    endtask

    initial begin
        int k0, s0, dcyc, t, e, cnt, idx, target, s1b, k2, k3, dc2;
        logic exp_rd;

        mem1[0] = 8'hA5;
        mem1[1] = 8'h3C;
        mem1[2] = 8'hFF;
        for (int i = 3; i < NB; i++) mem1[i] = 8'($urandom);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", tx1, 1);
        check("rst_busy", busy1, 0);
        check("rst_read", mif1.read, 0);
        check("rst_done", done1, 0);
        check("rst_adr", mif1.adr, 0);
        reset = 1'b0;
        quiet_check("idle_after_reset");

        // Full dump with a stray start in the middle.
        @(negedge clk);
        start1 = 1'b1;
        k0 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        s0 = k0 + 1 + RW;
        while (cyc < k0 + 200) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        t = 0;
        while (done1 !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done1_seen", done1, 1);
        dcyc = cyc;
        repeat (5) @(negedge clk);

        for (int i = 0; i < NB; i++)
            check($sformatf("frame%0d", i), frame_errs(1, s0 + i * PER, mem1[i]), 0);

        e = 0;
        for (int c = k0; c < s0; c++) if (tx1_log[c] !== 1'b1) e++;
        for (int i = 0; i < NB; i++)
            for (int c = s0 + i * PER + 10 * D; c < s0 + (i + 1) * PER && c <= dcyc + 4; c++)
                if (tx1_log[c] !== 1'b1) e++;
        check("tx_high_gaps", e, 0);

        e = 0;
        cnt = 0;
        for (int c = k0; c <= dcyc + 4; c++) begin
            exp_rd = 1'b0;
            idx = 0;
            for (int i = 0; i < NB; i++)
                if (c >= s0 + i * PER - RW && c < s0 + i * PER) begin
                    exp_rd = 1'b1;
                    idx = i;
                end
            if (read1_log[c] === 1'b1) cnt++;
            if (read1_log[c] !== exp_rd) e++;
            else if (exp_rd && adr1_log[c] !== 21'(idx)) e++;
        end
        check("read_adr_schedule", e, 0);
        check("read_cycles", cnt, NB * RW);

        check("done_cycle", dcyc, s0 + (NB - 1) * PER + 10 * D);
        cnt = 0;
        e = 0;
        for (int c = k0; c <= dcyc + 4; c++) begin
            if (done1_log[c] === 1'b1) cnt++;
            if (busy1_log[c] !== ((c > k0) && (c <= dcyc))) e++;
        end
        check("done_pulses", cnt, 1);
        check("busy_window", e, 0);

        // Reset during data bit 4 of byte 1 (a 0 bit, so tx must jump high).
        mem1[1] = 8'hC3;
        @(negedge clk);
        start1 = 1'b1;
        k2 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        s1b = k2 + 1 + RW + PER;
        target = s1b + 5 * D + 1;
        while (cyc < target) @(negedge clk);
        check("pre_reset_tx_low", tx1_log[target-1], 0);
        reset = 1'b1;
        #1;
        check("midrst_tx", tx1, 1);
        check("midrst_busy", busy1, 0);
        check("midrst_read", mif1.read, 0);
        check("midrst_done", done1, 0);
        check("midrst_adr", mif1.adr, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        quiet_check("idle_after_midrst");

        // Restart dumps from address 0 again.
        @(negedge clk);
        start1 = 1'b1;
        k2 = cyc;
        @(negedge clk);
        start1 = 1'b0;
        s0 = k2 + 1 + RW;
        while (cyc < s0 + PER + 10 * D + 2) @(negedge clk);
        check("restart_frame0", frame_errs(1, s0, mem1[0]), 0);
        check("restart_frame1", frame_errs(1, s0 + PER, mem1[1]), 0);
        t = 0;
        while (done1 !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("restart_done_seen", done1, 1);
        check("restart_done_cycle", cyc, s0 + (NB - 1) * PER + 10 * D);

        // LAST_ADR = 0: exactly one byte.
        @(negedge clk);
        start2 = 1'b1;
        k3 = cyc;
        @(negedge clk);
        start2 = 1'b0;
        t = 0;
        while (done2 !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("single_done_seen", done2, 1);
        dc2 = cyc;
        repeat (30) @(negedge clk);
        check("single_frame", frame_errs(2, k3 + 1 + RW, 8'h00), 0);
        check("single_done_cycle", dc2, k3 + 1 + RW + 10 * D);
        cnt = 0;
        e = 0;
        for (int c = k3; c < cyc; c++) begin
            if (read2_log[c] === 1'b1) cnt++;
            if (done2_log[c] === 1'b1) e++;
        end
        check("single_read_cycles", cnt, RW);
        check("single_done_pulses", e, 1);
        e = 0;
        for (int c = dc2; c < cyc; c++) if (tx2_log[c] !== 1'b1) e++;
        check("single_no_second_frame", e, 0);
        check("single_busy_low", busy2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
